// File: rtl/mdc_pkg.sv
// Shared constants and helpers for the MDC actor library.
package mdc_pkg;

  localparam int MDC_DATA_W     = 32;
  localparam int MDC_FIFO_DEPTH = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mdc_fifo_mem.sv
// DEPTH x SIZE storage array: synchronous write port, asynchronous read port, no reset.
// The read port is combinational so the buffer can present its head first-word-fall-through.
module mdc_fifo_mem
  import mdc_pkg::*;
#(
  parameter int SIZE   = MDC_DATA_W,
  parameter int DEPTH  = MDC_FIFO_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [SIZE-1:0]   i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [SIZE-1:0]   o_rd_data
);

  logic [SIZE-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/mdc_fifo_buffer.sv
// FWFT FIFO on the MDC write/full_n handshake; a write at edge N is visible at the head in cycle N+1.
// Flags are decoded from the registered count with no lookahead; sticky over/underflow error flags.
module mdc_fifo_buffer
  import mdc_pkg::*;
#(
  parameter int SIZE    = MDC_DATA_W,
  parameter int DEPTH   = MDC_FIFO_DEPTH,
  localparam int CNT_W  = clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SIZE-1:0]  in_data,
  input  logic             in_write,
  output logic             in_full_n,
  output logic [SIZE-1:0]  out_data,
  output logic             out_empty_n,
  input  logic             out_read,
  output logic [CNT_W-1:0] count,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int ADDR_W = clog2(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full_n;
  logic              w_empty_n;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [SIZE-1:0]   w_rd_data;

  assign w_full_n  = (r_count != CNT_W'(DEPTH));
  assign w_empty_n = (r_count != '0);
  assign w_wr_acc  = in_write & w_full_n;
  assign w_rd_acc  = out_read & w_empty_n;

  mdc_fifo_mem #(
    .SIZE   (SIZE),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock     (clock),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (in_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // DEPTH is a power of two, so pointer wrap is the natural ADDR_W-bit rollover.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (in_write && !w_full_n) r_overflow <= 1'b1;
      // A read against an empty buffer that coincides with a write is absorbed, not an error.
      if (out_read && !w_empty_n && !in_write) r_underflow <= 1'b1;
    end
  end

  assign in_full_n     = w_full_n;
  assign out_empty_n   = w_empty_n;
  assign out_data      = w_empty_n ? w_rd_data : '0;
  assign count         = r_count;
  assign overflow_err  = r_overflow;
  assign underflow_err = r_underflow;

endmodule

// File: tb/tb_mdc_fifo_buffer.sv
// Self-checking bench for mdc_fifo_buffer against a queue-based reference model.
module tb_mdc_fifo_buffer;

  localparam int SIZE  = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [SIZE-1:0]  in_data;
  logic             in_write;
  logic             in_full_n;
  logic [SIZE-1:0]  out_data;
  logic             out_empty_n;
  logic             out_read;
  logic [CNT_W-1:0] count;
  logic             overflow_err;
  logic             underflow_err;

  int checks = 0;
  int errors = 0;

  logic [SIZE-1:0] q[$];
  bit m_ovf;
  bit m_unf;

  mdc_fifo_buffer #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_data       (in_data),
    .in_write      (in_write),
    .in_full_n     (in_full_n),
    .out_data      (out_data),
    .out_empty_n   (out_empty_n),
    .out_read      (out_read),
    .count         (count),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clock = ~clock;

  // Drive one cycle of stimulus and advance the reference model by the handshake rules.
  task automatic cyc(input logic w, input logic r, input logic [SIZE-1:0] d);
    bit full, empty;
    in_write = w;
    out_read = r;
    in_data  = d;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    @(posedge clock);
    #1;
    if (w && full) m_ovf = 1'b1;
    if (r && empty && !w) m_unf = 1'b1;
    if (r && !empty) void'(q.pop_front());
    if (w && !full) q.push_back(d);
    in_write = 1'b0;
    out_read = 1'b0;
    in_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) cyc(1'b0, 1'b0, '0);
    checks++; if (in_full_n !== 1'b1) begin errors++; $display("FAIL reset_full_n: got %b expected 1", in_full_n); end
    checks++; if (out_empty_n !== 1'b0) begin errors++; $display("FAIL reset_empty_n: got %b expected 0", out_empty_n); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
    checks++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin errors++; $display("FAIL reset_errs: got %b%b expected 00", overflow_err, underflow_err); end
  endtask

  task automatic test_single();
    cyc(1'b1, 1'b0, 32'hA5A5_0001);
    checks++; if (out_empty_n !== 1'b1) begin errors++; $display("FAIL single_empty_n: got %b expected 1", out_empty_n); end
    checks++; if (out_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data: got %h expected a5a50001", out_data); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    cyc(1'b0, 1'b1, '0);
    checks++; if (out_empty_n !== 1'b0 || count !== 4'd0 || out_data !== 32'h0) begin
      errors++; $display("FAIL single_pop: got empty_n=%b count=%0d data=%h expected 0 0 0", out_empty_n, count, out_data);
    end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 32'(i));
    checks++; if (in_full_n !== 1'b0 || count !== 4'd8) begin
      errors++; $display("FAIL fill_full: got full_n=%b count=%0d expected 0 8", in_full_n, count);
    end
    cyc(1'b1, 1'b0, 32'hDEAD);
    checks++; if (overflow_err !== 1'b1 || count !== 4'd8 || out_data !== 32'h0) begin
      errors++; $display("FAIL fill_overflow: got ovf=%b count=%0d head=%h expected 1 8 0", overflow_err, count, out_data);
    end
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) for (int i = 8; i < 16; i++) cyc(1'b1, 1'b0, 32'(i));
      for (int i = 0; i < DEPTH; i++) begin
        checks++; if (out_data !== 32'(pass * 8 + i)) begin
          errors++; $display("FAIL fill_order: got %h expected %h", out_data, 32'(pass * 8 + i));
        end
        cyc(1'b0, 1'b1, '0);
      end
    end
    checks++; if (count !== 4'd0 || underflow_err !== 1'b0) begin
      errors++; $display("FAIL fill_drained: got count=%0d unf=%b expected 0 0", count, underflow_err);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 32'(20 + i));
    cyc(1'b1, 1'b1, 32'hBEEF);
    checks++; if (count !== 4'd7 || overflow_err !== 1'b1 || out_data !== 32'd21) begin
      errors++; $display("FAIL simul_full: got count=%0d ovf=%b head=%h expected 7 1 15", count, overflow_err, out_data);
    end
    repeat (7) cyc(1'b0, 1'b1, '0);
    cyc(1'b1, 1'b1, 32'h1234);
    checks++; if (count !== 4'd1 || out_data !== 32'h1234 || underflow_err !== 1'b0) begin
      errors++; $display("FAIL simul_empty: got count=%0d head=%h unf=%b expected 1 1234 0", count, out_data, underflow_err);
    end
    cyc(1'b0, 1'b1, '0);
    cyc(1'b0, 1'b1, '0);
    checks++; if (underflow_err !== 1'b1 || count !== 4'd0) begin
      errors++; $display("FAIL simul_underflow: got unf=%b count=%0d expected 1 0", underflow_err, count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'(100 + i));
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_data !== ((i < 3) ? 32'(100 + i) : 32'(200 + i - 3))) begin
        errors++; $display("FAIL b2b_order: got %h at step %0d", out_data, i);
      end
      cyc(1'b1, 1'b1, 32'(200 + i));
      checks++; if (count !== 4'd3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", count); end
    end
    repeat (3) cyc(1'b0, 1'b1, '0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'(300 + i));
    #3;
    reset = 1'b1;
    #1;
    checks++; if (in_full_n !== 1'b1 || out_empty_n !== 1'b0 || count !== 4'd0 || out_data !== 32'h0 ||
                  overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      errors++; $display("FAIL async_reset: got full_n=%b empty_n=%b count=%0d data=%h errs=%b%b expected 1 0 0 0 00",
                         in_full_n, out_empty_n, count, out_data, overflow_err, underflow_err);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    cyc(1'b1, 1'b0, 32'h00C0_FFEE);
    checks++; if (out_data !== 32'h00C0_FFEE || count !== 4'd1) begin
      errors++; $display("FAIL async_first: got head=%h count=%0d expected c0ffee 1", out_data, count);
    end
    cyc(1'b0, 1'b1, '0);
  endtask

  task automatic test_random();
    int wp, rp;
    logic [SIZE-1:0] exp_head;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      wp = (i % 200 < 100) ? 75 : 25;
      rp = 100 - wp;
      exp_head = (q.size() != 0) ? q[0] : '0;
      checks++; if (out_data !== exp_head || count !== CNT_W'(q.size()) ||
                    in_full_n !== (q.size() != DEPTH) || out_empty_n !== (q.size() != 0) ||
                    overflow_err !== m_ovf || underflow_err !== m_unf) begin
        errors++; $display("FAIL random_%0d: got data=%h count=%0d full_n=%b empty_n=%b errs=%b%b expected %h %0d %b %b %b%b",
                           i, out_data, count, in_full_n, out_empty_n, overflow_err, underflow_err,
                           exp_head, q.size(), q.size() != DEPTH, q.size() != 0, m_ovf, m_unf);
      end
      cyc(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < rp), $urandom);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_write = 1'b0;
    out_read = 1'b0;
    in_data  = '0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    #12;
    test_reset();
    test_single();
    test_fill_wrap();
    test_simultaneous();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
